pulse_period_meter: RTL
=======================

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter CLK_DIV, default 4, is the number of CLK cycles per timing tick; legal values are 2..65535.
REQ-002 Parameter DEBOUNCE, default 3, is the number of consecutive stable synchronized samples required to accept a level change; legal values are 1..255.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 PULSE_IN  input  1  raw heartbeat sensor level, asynchronous to CLK.
REQ-006 ACK  input  1  CPU acknowledge, driven from an output IO register bit; level-sampled each cycle.
REQ-007 PERIOD  output  8  last measured beat interval in ticks; wired to memory-mapped input port A.
REQ-008 STATUS  output  8  {4'b0, MISS, ARMED, OVF, VALID}; wired to memory-mapped input port B.

Function
REQ-009 PULSE_IN shall pass through a 2-flop synchronizer before any other use.
REQ-010 The debouncer shall update its output level only after the synchronized input has differed from that level for DEBOUNCE consecutive cycles; any agreeing sample restarts the count.
REQ-011 A beat shall be a single-cycle pulse on the cycle the debounced level rises 0->1; a falling edge shall not produce a beat.
REQ-012 The prescaler shall count 0..CLK_DIV-1 and emit a one-cycle tick on wrap; a beat shall reset the prescaler to 0.
REQ-013 The 8-bit interval counter shall increment on each tick, saturate at 255 without wrapping, and clear to 0 on a beat.
REQ-014 The FSM shall have two states: IDLE and ARMED; IDLE -> ARMED on the first beat with no PERIOD update; ARMED shall persist until reset.
REQ-015 On a beat in ARMED, PERIOD shall load the interval count, VALID shall set, and OVF shall equal (count == 255); the outputs shall update one cycle after the beat pulse.
REQ-016 A beat and a tick in the same cycle: the beat wins, and the counter clears rather than incrementing.
REQ-017 A beat in ARMED while VALID is already 1 shall still update PERIOD and OVF, and shall set MISS.
REQ-018 ACK=1 shall clear VALID and MISS; if ACK and a measuring beat coincide, VALID shall remain 1, and MISS shall clear unless that beat itself sets MISS.
REQ-019 STATUS bit 2 shall reflect the state (1 = ARMED); bits 7:4 shall be 0.

Reset
REQ-020 While RESET=1, regardless of CLK: PERIOD=0, STATUS=0, FSM=IDLE, synchronizer/debounce/prescaler/interval counters=0, debounced level=0.
REQ-021 Reset asserted mid-interval shall discard the partial count; the first beat after release shall only arm.

Configuration
REQ-022 Macro PULSE_METER_AVG_EN defined: PERIOD on each measuring beat except the first after arming = (count + previous raw count) >> 1, computed 9-bit, truncated; OVF still derives from the raw count.
REQ-023 Macro PULSE_METER_AVG_EN undefined: PERIOD = raw count; no previous-count register is instantiated.

Verification
REQ-024 Reset released, PULSE_IN held 0 for 1000 cycles -> PERIOD=0, STATUS=8'h00.
REQ-025 CLK_DIV=4, DEBOUNCE=3; clean rising edges 40 cycles apart -> after first edge STATUS=8'h04; after second PERIOD=10, STATUS=8'h05.
REQ-026 Glitch: PULSE_IN high for 2 cycles only -> no beat; STATUS unchanged.
REQ-027 Beats 1200 cycles apart (CLK_DIV=4) -> PERIOD=255, STATUS=8'h07; ACK pulse -> STATUS=8'h06.
REQ-028 Three beats 40 cycles apart, no ACK -> STATUS=8'h0D; ACK coinciding with 4th beat -> STATUS=8'h05.
REQ-029 AVG_EN defined, intervals 40 then 80 cycles -> PERIOD=10, then 15.

Source files
------------

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - heartbeat interval meter: sync, debounce, tick counter, status
// Optional feature: define PULSE_METER_AVG_EN to report the mean of the last two intervals.
module pulse_period_meter #(
    parameter int CLK_DIV  = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PULSE_IN,
    input  logic       ACK,
    output logic [7:0] PERIOD,
    output logic [7:0] STATUS
);

    localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);
    localparam logic [7:0]  DEB_MAX   = 8'(DEBOUNCE - 1);
    localparam logic [7:0]  CNT_SAT   = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic        sync1_q, sync2_q;
    logic        deb_level_q, deb_prev_q;
    logic [7:0]  deb_cnt_q;
    logic [15:0] presc_q;
    logic [7:0]  cnt_q;
    logic [7:0]  period_q, period_d;
    logic        valid_q, ovf_q, miss_q;

    logic        beat;
    logic        tick;
    logic        measure;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= PULSE_IN;
            sync2_q <= sync1_q;
        end
    end

    // Any sample agreeing with the accepted level restarts the stability count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_level_q <= 1'b0;
            deb_cnt_q   <= 8'd0;
            deb_prev_q  <= 1'b0;
        end else begin
            deb_prev_q <= deb_level_q;
            if (sync2_q == deb_level_q) begin
                deb_cnt_q <= 8'd0;
            end else if (deb_cnt_q == DEB_MAX) begin
                deb_level_q <= sync2_q;
                deb_cnt_q   <= 8'd0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 8'd1;
            end
        end
    end

    assign beat = deb_level_q & ~deb_prev_q;
    assign tick = (presc_q == PRESC_MAX);

    // The beat cycle itself is prescaler phase 0, so the register resumes at phase 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_q <= 16'd0;
        end else if (beat) begin
            presc_q <= 16'd1;
        end else if (tick) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= 8'd0;
        end else if (beat) begin
            cnt_q <= 8'd0;
        end else if (tick && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        measure = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                measure = beat;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PULSE_METER_AVG_EN
    logic [7:0] prev_cnt_q;
    logic       have_prev_q;
    logic [8:0] sum;

    assign sum = {1'b0, cnt_q} + {1'b0, prev_cnt_q};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_cnt_q  <= 8'd0;
            have_prev_q <= 1'b0;
        end else if (measure) begin
            prev_cnt_q  <= cnt_q;
            have_prev_q <= 1'b1;
        end
    end

    always_comb begin
        period_d = cnt_q;
        if (have_prev_q) begin
            period_d = 8'(sum >> 1);
        end
    end
`else
    always_comb begin
        period_d = cnt_q;
    end
`endif

    // An ACK in the same cycle consumes the old VALID, so a coinciding beat is not a miss.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            period_q <= 8'd0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            if (measure) begin
                period_q <= period_d;
                ovf_q    <= (cnt_q == CNT_SAT);
            end
            valid_q <= measure | (valid_q & ~ACK);
            miss_q  <= ~ACK & (miss_q | (measure & valid_q));
        end
    end

    assign PERIOD = period_q;
    assign STATUS = {4'b0000, miss_q, (state_q == ARMED), ovf_q, valid_q};

endmodule
